// File: rtl/mmio_bridge.sv
// Memory-stage MMIO bridge: passes plain loads/stores to data memory and turns
// high-address accesses into single outstanding peripheral transactions.

// One peripheral channel slot: qualifies the ack and gates that channel's data.
module mmio_bridge_ch #(
  parameter int DW = 32
) (
  input  logic          req,
  input  logic          ack,
  input  logic [DW-1:0] rdata_in,
  output logic          hit,
  output logic [DW-1:0] rdata_out
);
  assign hit       = req & ack;
  assign rdata_out = hit ? rdata_in : '0;
endmodule

module mmio_bridge #(
  parameter int DW      = 32,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic              req_rd,
  input  logic              req_wr,
  output logic              dm_re,
  output logic              dm_we,
  output logic              stall,
  output logic [DW-1:0]     rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [NCH-1:0]    ch_req,
  output logic              ch_we,
  output logic [11:0]       ch_addr,
  output logic [DW-1:0]     ch_wdata,
  input  logic [NCH-1:0]    ch_ack,
  input  logic [NCH*DW-1:0] ch_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] NCH_W    = 4'(NCH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [NCH-1:0]       ch_req_q, ch_req_d;
  logic                 ch_we_q, ch_we_d;
  logic [11:0]          ch_addr_q, ch_addr_d;
  logic [DW-1:0]        ch_wdata_q, ch_wdata_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           err_count_q, err_count_d;

  logic                 io_hit, io_req, sel_bad, ack_hit, err_inc;
  logic [2:0]           sel;
  logic [NCH-1:0]       ch_hit;
  logic [NCH-1:0][DW-1:0] ch_rd_m;
  logic [DW-1:0]        ack_rdata;
  logic                 unused_addr;

  assign unused_addr = req_addr[15];

  // ch_req_q is one-hot at the registered select in WAIT, so it doubles as the ack mask.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    mmio_bridge_ch #(.DW(DW)) u_ch (
      .req      (ch_req_q[k]),
      .ack      (ch_ack[k]),
      .rdata_in (ch_rdata[k*DW +: DW]),
      .hit      (ch_hit[k]),
      .rdata_out(ch_rd_m[k])
    );
  end

  always_comb begin
    ack_rdata = '0;
    for (int k = 0; k < NCH; k++) ack_rdata = ack_rdata | ch_rd_m[k];
  end

  assign io_hit  = |req_addr[31:16];
  assign io_req  = io_hit & (req_rd | req_wr);
  assign sel     = req_addr[14:12];
  assign sel_bad = {1'b0, sel} >= NCH_W;
  assign ack_hit = |ch_hit;

  assign dm_re = req_rd & ~io_hit;
  assign dm_we = req_wr & ~io_hit;
  assign stall = ((state_q == S_IDLE) & io_req) | (state_q == S_WAIT);

  always_comb begin
    state_d    = state_q;
    ch_req_d   = ch_req_q;
    ch_we_d    = ch_we_q;
    ch_addr_d  = ch_addr_q;
    ch_wdata_d = ch_wdata_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io_req) begin
          if ((req_rd & req_wr) | sel_bad) begin
            state_d = S_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
            err_inc = 1'b1;
          end else begin
            state_d    = S_WAIT;
            ch_req_d   = NCH'(1) << sel;
            ch_we_d    = req_wr;
            ch_addr_d  = req_addr[11:0];
            ch_wdata_d = req_wdata;
            wait_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // An ack in the expiry cycle is checked first so it beats the timeout.
        if (ack_hit) begin
          state_d  = S_RESP;
          ch_req_d = '0;
          ch_we_d  = 1'b0;
          rdata_d  = ch_we_q ? '0 : ack_rdata;
          err_d    = 1'b0;
        end else if (wait_cnt_q == TMO_LAST) begin
          state_d  = S_RESP;
          ch_req_d = '0;
          ch_we_d  = 1'b0;
          rdata_d  = '0;
          err_d    = 1'b1;
          err_inc  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_count_d = (err_inc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_req_q    <= '0;
      ch_we_q     <= 1'b0;
      ch_addr_q   <= '0;
      ch_wdata_q  <= '0;
      wait_cnt_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_req_q    <= ch_req_d;
      ch_we_q     <= ch_we_d;
      ch_addr_q   <= ch_addr_d;
      ch_wdata_q  <= ch_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign rdata_valid = (state_q == S_RESP);
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign ch_req      = ch_req_q;
  assign ch_we       = ch_we_q;
  assign ch_addr     = ch_addr_q;
  assign ch_wdata    = ch_wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge (DW=32, NCH=4, TIMEOUT=16); inputs change and
// outputs are sampled just after the falling edge.
module tb_mmio_bridge;
  localparam int DW = 32, NCH = 4, TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       req_addr;
  logic [DW-1:0]     req_wdata;
  logic              req_rd, req_wr;
  logic              dm_re, dm_we, stall, rdata_valid, err, ch_we;
  logic [DW-1:0]     rdata, ch_wdata;
  logic [7:0]        err_count;
  logic [NCH-1:0]    ch_req, ch_ack;
  logic [11:0]       ch_addr;
  logic [NCH*DW-1:0] ch_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_bridge #(.DW(DW), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .req_wr(req_wr), .dm_re(dm_re), .dm_we(dm_we),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .err_count(err_count), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_in();
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; ch_ack = '0;
  endtask

  initial begin
    rst = 1'b1; idle_in(); ch_rdata = '0;
    // reset state
    nxt(); #1;
    chk("rst_ch_req", 64'(ch_req), 64'd0);
    chk("rst_valid", 64'(rdata_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    nxt(); rst = 1'b0;

    // IO read ch1 offset 0x004, ack in first WAIT cycle
    nxt(); req_rd = 1'b1; req_addr = 32'h0001_1004; #1;
    chk("rd_idle_stall", 64'(stall), 64'd1);
    chk("rd_idle_dm_re", 64'(dm_re), 64'd0);
    chk("rd_idle_ch_req", 64'(ch_req), 64'd0);
    nxt(); ch_ack = 4'b0010; ch_rdata[1*DW +: DW] = 32'hDEAD_BEEF; #1;
    chk("rd_wait_ch_req", 64'(ch_req), 64'h2);
    chk("rd_wait_addr", 64'(ch_addr), 64'h004);
    chk("rd_wait_we", 64'(ch_we), 64'd0);
    chk("rd_wait_stall", 64'(stall), 64'd1);
    nxt(); ch_ack = '0; #1;
    chk("rd_resp_valid", 64'(rdata_valid), 64'd1);
    chk("rd_resp_rdata", 64'(rdata), 64'hDEAD_BEEF);
    chk("rd_resp_err", 64'(err), 64'd0);
    chk("rd_resp_stall", 64'(stall), 64'd0);
    chk("rd_resp_ch_req", 64'(ch_req), 64'd0);
    nxt(); idle_in(); #1;
    chk("rd_after_valid", 64'(rdata_valid), 64'd0);
    chk("rd_after_hold", 64'(rdata), 64'hDEAD_BEEF);

    // data-memory store stays out of the FSM
    nxt(); req_wr = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h0BAD_F00D; #1;
    chk("dm_we", 64'(dm_we), 64'd1);
    chk("dm_re", 64'(dm_re), 64'd0);
    chk("dm_stall", 64'(stall), 64'd0);
    nxt(); #1;
    chk("dm_ch_req", 64'(ch_req), 64'd0);
    chk("dm_valid", 64'(rdata_valid), 64'd0);
    chk("dm_stall2", 64'(stall), 64'd0);
    nxt(); idle_in();

    // IO write ch2 with no ack: 16 WAIT cycles then error
    nxt(); req_wr = 1'b1; req_addr = 32'h0001_2008; req_wdata = 32'h1234_5678; #1;
    chk("to_idle_stall", 64'(stall), 64'd1);
    for (int i = 0; i < TIMEOUT; i++) begin
      nxt(); #1;
      chk($sformatf("to_wait%0d_ch_req", i), 64'(ch_req), 64'h4);
      chk($sformatf("to_wait%0d_stall", i), 64'(stall), 64'd1);
    end
    chk("to_ch_we", 64'(ch_we), 64'd1);
    chk("to_ch_addr", 64'(ch_addr), 64'h008);
    chk("to_ch_wdata", 64'(ch_wdata), 64'h1234_5678);
    nxt(); #1;
    chk("to_resp_valid", 64'(rdata_valid), 64'd1);
    chk("to_resp_err", 64'(err), 64'd1);
    chk("to_resp_rdata", 64'(rdata), 64'd0);
    chk("to_resp_ch_req", 64'(ch_req), 64'd0);
    nxt(); idle_in(); #1;
    chk("to_errcnt", 64'(err_count), 64'd1);
    chk("to_err_hold", 64'(err), 64'd1);

    // ack on the last counted WAIT cycle beats the timeout
    nxt(); req_rd = 1'b1; req_addr = 32'h0001_0020; #1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      nxt(); #1;
      chk($sformatf("edge_wait%0d_ch_req", i), 64'(ch_req), 64'h1);
    end
    nxt(); ch_ack = 4'b0001; ch_rdata[0 +: DW] = 32'h5A5A_5A5A; #1;
    chk("edge_last_ch_req", 64'(ch_req), 64'h1);
    nxt(); ch_ack = '0; #1;
    chk("edge_resp_valid", 64'(rdata_valid), 64'd1);
    chk("edge_resp_err", 64'(err), 64'd0);
    chk("edge_resp_rdata", 64'(rdata), 64'h5A5A_5A5A);
    nxt(); idle_in(); #1;
    chk("edge_errcnt", 64'(err_count), 64'd1);

    // stray ack on ch0 ignored, then ch0+ch3 together completes with ch3 data
    nxt(); req_rd = 1'b1; req_addr = 32'h0001_3010; ch_rdata[0 +: DW] = 32'h1111_1111; #1;
    nxt(); ch_ack = 4'b0001; #1;
    chk("stray_ch_req", 64'(ch_req), 64'h8);
    nxt(); #1;
    chk("stray_still_wait", 64'(ch_req), 64'h8);
    chk("stray_no_valid", 64'(rdata_valid), 64'd0);
    ch_ack = 4'b1001; ch_rdata[3*DW +: DW] = 32'hCAFE_F00D;
    nxt(); ch_ack = '0; #1;
    chk("both_resp_valid", 64'(rdata_valid), 64'd1);
    chk("both_resp_rdata", 64'(rdata), 64'hCAFE_F00D);
    chk("both_resp_err", 64'(err), 64'd0);

    // back-to-back: invalid channel (sel=6) right after RESP
    nxt(); req_rd = 1'b1; req_addr = 32'h0001_6000; #1;
    chk("inv_idle_stall", 64'(stall), 64'd1);
    chk("inv_idle_ch_req", 64'(ch_req), 64'd0);
    nxt(); #1;
    chk("inv_resp_valid", 64'(rdata_valid), 64'd1);
    chk("inv_resp_err", 64'(err), 64'd1);
    chk("inv_resp_rdata", 64'(rdata), 64'd0);
    chk("inv_resp_ch_req", 64'(ch_req), 64'd0);
    nxt(); idle_in(); #1;
    chk("inv_errcnt", 64'(err_count), 64'd2);

    // simultaneous rd+wr to IO is an error without channel access
    nxt(); req_rd = 1'b1; req_wr = 1'b1; req_addr = 32'h0001_0000; #1;
    chk("rw_dm_we", 64'(dm_we), 64'd0);
    nxt(); #1;
    chk("rw_resp_err", 64'(err), 64'd1);
    chk("rw_resp_ch_req", 64'(ch_req), 64'd0);
    nxt(); idle_in(); #1;
    chk("rw_errcnt", 64'(err_count), 64'd3);

    // reset on the third WAIT cycle
    nxt(); req_rd = 1'b1; req_addr = 32'h0001_1000;
    nxt(); nxt(); nxt(); #1;
    chk("rstw_ch_req_before", 64'(ch_req), 64'h2);
    rst = 1'b1; #1;
    chk("rstw_ch_req", 64'(ch_req), 64'd0);
    chk("rstw_errcnt", 64'(err_count), 64'd0);
    chk("rstw_valid", 64'(rdata_valid), 64'd0);
    chk("rstw_err", 64'(err), 64'd0);
    chk("rstw_stall_idle_term", 64'(stall), 64'd1);
    nxt(); rst = 1'b0; idle_in(); #1;
    chk("rstw_after_ch_req", 64'(ch_req), 64'd0);
    chk("rstw_after_stall", 64'(stall), 64'd0);
    nxt(); req_rd = 1'b1; req_addr = 32'h0001_1000; #1;
    nxt(); ch_ack = 4'b0010; ch_rdata[1*DW +: DW] = 32'h0BAD_C0DE; #1;
    chk("rstw_new_ch_req", 64'(ch_req), 64'h2);
    nxt(); ch_ack = '0; #1;
    chk("rstw_new_valid", 64'(rdata_valid), 64'd1);
    chk("rstw_new_rdata", 64'(rdata), 64'h0BAD_C0DE);
    chk("rstw_new_err", 64'(err), 64'd0);
    nxt(); idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DW, 32, data width.
- NCH, 4, peripheral channel count, legal range 1..8.
- TIMEOUT, 16, WAIT cycles before abort, legal range 2..255.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- req_addr  in  32  memory-stage byte address.
- req_wdata  in  DW  store data.
- req_rd  in  1  load request.
- req_wr  in  1  store request.
- dm_re  out  1  data-memory read enable.
- dm_we  out  1  data-memory write enable.
- stall  out  1  freeze pipeline.
- rdata  out  DW  IO load result.
- rdata_valid  out  1  rdata and err qualifier.
- err  out  1  transaction aborted.
- err_count  out  8  saturating abort counter.
- ch_req  out  NCH  one-hot peripheral select.
- ch_we  out  1  peripheral write.
- ch_addr  out  12  peripheral offset.
- ch_wdata  out  DW  peripheral write data.
- ch_ack  in  NCH  peripheral completion.
- ch_rdata  in  NCH*DW  peripheral read data; channel k occupies bits [k*DW +: DW].

Function
REQ-004 io_hit SHALL be high when req_addr[31:16] is nonzero; otherwise the access targets data memory.
REQ-005 dm_re SHALL equal req_rd & ~io_hit, and dm_we SHALL equal req_wr & ~io_hit, both combinational and independent of FSM state.
REQ-006 Channel select sel SHALL be req_addr[14:12]; sel >= NCH SHALL be an invalid channel.
REQ-007 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-008 In IDLE, a request (req_rd xor req_wr, with io_hit) SHALL register addr[11:0], wdata, we=req_wr and sel, then move to WAIT.
- Exception: if sel is invalid, the FSM SHALL move directly to RESP with err pending.
REQ-009 In IDLE, req_rd & req_wr both high with io_hit SHALL be an error: go to RESP with err pending, no channel access.
REQ-010 In WAIT, ch_req SHALL be one-hot at the registered sel, and ch_we, ch_addr and ch_wdata SHALL be held stable.
- All outputs in REQ-010 SHALL be registered; ch_req SHALL be 0 in IDLE and RESP.
REQ-011 In WAIT, ch_ack[sel] high SHALL move the FSM to RESP and capture ch_rdata[sel] (captured only for reads; 0 for writes).
- Acks on any other channel, and any ack in IDLE or RESP, SHALL be ignored.
REQ-012 The WAIT cycle counter SHALL clear on entry to WAIT.
- If TIMEOUT cycles elapse without ack, the FSM SHALL move to RESP with err pending and rdata=0.
- An ack arriving in the same cycle the count expires SHALL win: no error.
REQ-013 stall SHALL be combinational high in IDLE while an IO request is present, and high throughout WAIT.
- stall SHALL be low in RESP, so the pipeline advances at the end of RESP.
REQ-014 RESP SHALL last exactly one cycle with rdata_valid=1 and err set as pending.
- RESP SHALL return to IDLE and SHALL NOT sample the request inputs.
REQ-015 rdata and err SHALL hold their values until the next RESP.
REQ-016 err_count SHALL increment on each RESP with err=1 and saturate at 255.
REQ-017 Minimum IO latency SHALL be 3 cycles (IDLE sample, WAIT with same-cycle ack, RESP), and stall SHALL be high for exactly 2 of those cycles.
REQ-018 Back-to-back IO requests SHALL be accepted from IDLE on the cycle after RESP.

Reset
REQ-019 On rst assertion, at any time including mid-WAIT, the following SHALL apply:
- The FSM SHALL go to IDLE.
- ch_req, ch_we, rdata_valid, err and rdata SHALL be cleared immediately.
- err_count SHALL be 0 and the counter cleared.
- stall SHALL reflect only the combinational IDLE term.
REQ-020 There SHALL be no partial transaction resumption after reset deassertion.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- IO read, same-cycle ack: req_rd=1, req_addr=0x0001_1004, ack on ch1 in the first WAIT cycle with ch_rdata[1]=0xDEAD_BEEF -> ch_req=4'b0010, ch_addr=0x004, stall high for 2 cycles, RESP rdata=0xDEADBEEF, err=0.
- Data-memory store: req_wr=1, req_addr=0x0000_0040 -> dm_we=1, stall=0, ch_req stays 0, FSM stays IDLE.
- Timeout: IO write to ch2 with no ack -> ch_req=4'b0100 for 16 cycles, RESP err=1, rdata=0, err_count=1.
- Invalid channel: NCH=4, req_addr=0x0001_6000 -> ch_req never asserted, RESP after 1 cycle with err=1.
- Simultaneous/stray ack: ack on ch0 and ch3 while waiting on ch3 -> completes with ch3 data; ack on ch0 alone in WAIT -> no completion.
- Reset mid-WAIT: rst pulse on cycle 3 of WAIT -> ch_req=0 in the same cycle, err_count=0, the following request is handled normally.
